car_sensor_qualifier: RTL and testbench

Upstream stage of the highway/country-road signal controller. Takes the raw country-road vehicle loop detector and produces the qualified car-waiting request `x` that the controller consumes. The block synchronises, debounces and arms the request. It caps how long a request may be held, then enforces a hold-off so the highway regains green before the next request.

---
 rtl/traffic_pkg.sv | 23 ++
 rtl/sync_debounce.sv | 47 ++++
 rtl/car_sensor_qualifier.sv | 109 ++++++++++
 tb/tb_car_sensor_qualifier.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings for the highway/country-road signal controller and its
// car sensor qualifier front end.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    REQ  = 2'b10,
    HOLD = 2'b11
  } state_e;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a debounce filter: the filtered value only
// flips once the synchronised input has differed from it for DEBOUNCE cycles.
module sync_debounce #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = $clog2(DEBOUNCE) + 1;
  localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE - 1);

  logic          s1_q, s2_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (s2_q != filt_q) begin
      if (cnt_q == CntLast) begin
        filt_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/car_sensor_qualifier.sv
// Turns the raw country-road loop detector into the qualified car request x:
// synchronise/debounce, arm, cap the request length, then enforce a hold-off.
module car_sensor_qualifier
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned ARM_CYC  = 3,
  parameter int unsigned MAX_REQ  = 20,
  parameter int unsigned HOLDOFF  = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sensor_raw,
  output logic             x,
  output logic             timeout,
  output logic [CNT_W-1:0] car_count,
  output logic [1:0]       state
);

  localparam int unsigned TW = $clog2(max3(ARM_CYC, MAX_REQ, HOLDOFF)) + 1;
  localparam logic [TW-1:0] ArmLast  = TW'(ARM_CYC - 1);
  localparam logic [TW-1:0] ReqLast  = TW'(MAX_REQ - 1);
  localparam logic [TW-1:0] HoldLast = TW'(HOLDOFF - 1);

  logic             filt;
  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             timeout_q, timeout_d;

  sync_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sensor_raw),
    .dout  (filt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      cnt_q     <= '0;
      x_q       <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      timeout_q <= timeout_d;
    end
  end

  // Timer is shared by all states and cleared on every state entry.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (filt) state_d = ARM;
      end
      ARM: begin
        if (!filt) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == ArmLast) begin
          state_d = REQ;
          timer_d = '0;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      REQ: begin
        // A car leaving on the expiry edge is a normal end, not a timeout.
        if (!filt) begin
          state_d = HOLD;
          timer_d = '0;
        end else if (timer_q == ReqLast) begin
          state_d   = HOLD;
          timer_d   = '0;
          timeout_d = 1'b1;
        end
      end
      HOLD: begin
        if (timer_q == HoldLast) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
    x_d = (state_d == REQ);
  end

  assign x         = x_q;
  assign timeout   = timeout_q;
  assign car_count = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_car_sensor_qualifier.sv
// Directed bench: a default-parameter instance plus a DEBOUNCE=1 instance used
// where the default debounce makes an early drop during ARM impossible.
module tb_car_sensor_qualifier;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sensor, sensor_b;
  logic       x, timeout, x_b, timeout_b;
  logic [7:0] cnt, cnt_b;
  logic [1:0] st, st_b;

  int total = 0;
  int bad   = 0;
  logic x_seen, to_seen, nz_seen, xb_seen;

  always #5 clk = ~clk;

  car_sensor_qualifier u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sensor_raw (sensor),
    .x          (x),
    .timeout    (timeout),
    .car_count  (cnt),
    .state      (st)
  );

  car_sensor_qualifier #(
    .DEBOUNCE (1)
  ) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .sensor_raw (sensor_b),
    .x          (x_b),
    .timeout    (timeout_b),
    .car_count  (cnt_b),
    .state      (st_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    x_seen = 1'b0; to_seen = 1'b0; nz_seen = 1'b0; xb_seen = 1'b0;
  endtask

  // Advance n rising edges, sampling on each following falling edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      x_seen  = x_seen | x;
      to_seen = to_seen | timeout;
      nz_seen = nz_seen | (st != 2'b00);
      xb_seen = xb_seen | x_b;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sensor = 1'b0; sensor_b = 1'b0;
    clr();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk("rst_x", x, 0);
    chk("rst_state", st, 0);
    chk("rst_count", cnt, 0);
    chk("rst_timeout", timeout, 0);

    // Idle with no car
    clr(); run(50);
    chk("idle_x", x_seen, 0);
    chk("idle_timeout", to_seen, 0);
    chk("idle_state", nz_seen, 0);
    chk("idle_count", cnt, 0);

    // Held car: rise at edge 9, forced drop after 20 cycles, re-arm at edge 41
    sensor = 1'b1;
    run(9);
    chk("rise_e8_x", x, 0);
    run(1);
    chk("rise_e9_x", x, 1);
    chk("rise_e9_count", cnt, 1);
    chk("rise_e9_state", st, 2);
    clr(); run(19);
    chk("req_e28_x", x, 1);
    chk("req_no_timeout", to_seen, 0);
    run(1);
    chk("tmo_e29_x", x, 0);
    chk("tmo_e29_pulse", timeout, 1);
    chk("tmo_e29_state", st, 3);
    clr(); run(1);
    chk("tmo_e30_pulse", timeout, 0);
    run(10);
    chk("holdoff_x_low", x_seen, 0);
    chk("rearm_e40_state", st, 1);
    run(1);
    chk("rearm_e41_x", x, 1);
    chk("rearm_e41_count", cnt, 2);

    // Car leaves while in REQ: x falls 6 edges after first low sample
    sensor = 1'b0;
    clr(); run(6);
    chk("fall_e5_x", x, 1);
    run(1);
    chk("fall_e6_x", x, 0);
    chk("fall_e6_state", st, 3);
    chk("fall_no_timeout", to_seen, 0);
    run(7);
    chk("fall_hold_state", st, 3);
    run(1);
    chk("fall_idle_state", st, 0);
    chk("fall_count", cnt, 2);

    // Car leaves exactly on the expiry edge: no timeout pulse
    sensor = 1'b1;
    run(10);
    chk("tie_rise_x", x, 1);
    chk("tie_rise_count", cnt, 3);
    run(13);
    sensor = 1'b0;
    run(6);
    chk("tie_e28_x", x, 1);
    clr(); run(1);
    chk("tie_e29_x", x, 0);
    chk("tie_e29_timeout", timeout, 0);
    chk("tie_e29_state", st, 3);
    run(20);
    chk("tie_no_timeout", to_seen, 0);
    chk("tie_idle_state", st, 0);

    // 3-cycle glitches never pass the debounce filter
    clr();
    for (int i = 0; i < 10; i++) begin
      sensor = 1'b1; run(3);
      sensor = 1'b0; run(3);
    end
    run(10);
    chk("glitch_state", nz_seen, 0);
    chk("glitch_x", x_seen, 0);
    chk("glitch_count", cnt, 3);

    // DEBOUNCE=1 instance: rise at edge 6, then drop during ARM
    sensor_b = 1'b1;
    run(6);
    chk("b_rise_e5_x", x_b, 0);
    run(1);
    chk("b_rise_e6_x", x_b, 1);
    chk("b_rise_count", cnt_b, 1);
    sensor_b = 1'b0;
    run(15);
    chk("b_settle_state", st_b, 0);
    clr();
    sensor_b = 1'b1; run(2);
    sensor_b = 1'b0; run(2);
    chk("b_arm_state", st_b, 1);
    run(2);
    chk("b_drop_state", st_b, 0);
    run(10);
    chk("b_drop_x", xb_seen, 0);
    chk("b_drop_count", cnt_b, 1);

    // Asynchronous reset while x is high
    sensor = 1'b1;
    run(10);
    chk("prerst_x", x, 1);
    chk("prerst_count", cnt, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x", x, 0);
    chk("arst_count", cnt, 0);
    chk("arst_state", st, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(9);
    chk("postrst_e8_x", x, 0);
    run(1);
    chk("postrst_e9_x", x, 1);
    chk("postrst_count", cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
